// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: sends one byte as an 11-bit frame on a self-generated
// PS/2 clock, aborting and retransmitting when the host inhibits mid-frame.
module ps2_device_tx #(
   parameter int unsigned HALF_PERIOD = 2500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       host_inhibit,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       tx_done
);

   localparam int unsigned   CW       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);
   localparam logic [3:0]    LAST_IDX = 4'd10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_LOW   = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;

   logic          inh_s1_q, inh_s2_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic          last_q, last_d;
   logic [7:0]    byte_q, byte_d;
   logic          par_q, par_d;
   logic          clk_q, clk_d;
   logic          data_q, data_d;
   logic          done_q, done_d;
   logic          inhibit, cnt_end, abort;
   logic [10:0]   frame_d;

   assign inhibit  = inh_s2_q;
   assign cnt_end  = (cnt_q == CNT_LAST);
   assign tx_ready = (state_q == S_IDLE) && !inhibit;
   assign ps2_clk  = clk_q;
   assign ps2_data = data_q;
   assign tx_done  = done_q;

   // last_q marks that the stop bit's falling edge has happened; past that point inhibit is ignored
   assign abort = inhibit && !last_q &&
                  ((state_q == S_SETUP) || (state_q == S_HIGH) ||
                   ((state_q == S_LOW) && (idx_q != LAST_IDX)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      last_d  = last_q;
      byte_d  = byte_q;
      par_d   = par_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (tx_valid && tx_ready) begin
               byte_d  = tx_data;
               par_d   = ~^tx_data;
               idx_d   = '0;
               last_d  = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: if (cnt_end) state_d = S_LOW;
         S_LOW: begin
            if (cnt_end) begin
               state_d = S_HIGH;
               if (idx_q < LAST_IDX) idx_d = idx_q + 4'd1;
               else                  last_d = 1'b1;
            end
         end
         S_HIGH: if (cnt_end) state_d = last_q ? S_GAP : S_LOW;
         S_GAP: begin
            if (cnt_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_HOLD: begin
            if (inhibit) begin
               cnt_d = '0;
            end else if (cnt_end) begin
               state_d = S_SETUP;
               idx_d   = '0;
               last_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_HOLD;
      if (state_d != state_q) cnt_d = '0;

      // Outputs are registered from the next state so the clock edge and its data move together
      frame_d = {1'b1, par_d, byte_d, 1'b0};
      clk_d   = (state_d != S_LOW);
      data_d  = 1'b1;
      if ((state_d == S_SETUP) || (state_d == S_LOW) || (state_d == S_HIGH))
         data_d = frame_d[idx_d];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inh_s1_q <= 1'b0;
         inh_s2_q <= 1'b0;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         last_q   <= 1'b0;
         byte_q   <= '0;
         par_q    <= 1'b0;
         clk_q    <= 1'b1;
         data_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         inh_s1_q <= host_inhibit;
         inh_s2_q <= inh_s1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         byte_q   <= byte_d;
         par_q    <= par_d;
         clk_q    <= clk_d;
         data_q   <= data_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: time-based frame model checked every cycle, plus literal
// host-side frame captures, latencies and edge counts for directed scenarios.
module tb_ps2_device_tx;

   localparam int HP = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       host_inhibit;
   logic       ps2_clk;
   logic       ps2_data;
   logic       tx_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int falls = 0;
   logic samp[$];
   int   acc_q[$];
   int   done_q[$];
   logic done_rdy_q[$];

   ps2_device_tx #(.HALF_PERIOD(HP)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .host_inhibit(host_inhibit), .ps2_clk(ps2_clk),
      .ps2_data(ps2_data), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 framing (t = cycles since accept), 2 held off by host
   int         m_mode, m_t, m_hold;
   logic [7:0] m_byte;
   logic       m_s1, m_s2, m_done;

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (i == 9) return ~^b;
      return 1'b1;
   endfunction

   function automatic logic exp_clk(input int mode, input int t);
      int h;
      if (mode != 1) return 1'b1;
      h = t / HP;
      if (h >= 1 && h <= 22 && ((h - 1) % 2 == 0)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic exp_data(input int mode, input int t, input logic [7:0] b);
      int h, k;
      if (mode != 1) return 1'b1;
      h = t / HP;
      if (h == 0) return 1'b0;
      if (h > 22) return 1'b1;
      k = (h - 1) / 2;
      if ((h - 1) % 2 == 0) return frame_bit(b, k);
      return frame_bit(b, (k + 1 > 10) ? 10 : k + 1);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode <= 0; m_t <= 0; m_hold <= 0; m_byte <= '0;
         m_s1 <= 1'b0; m_s2 <= 1'b0; m_done <= 1'b0;
      end else begin
         m_s1   <= host_inhibit;
         m_s2   <= m_s1;
         m_done <= 1'b0;
         case (m_mode)
            0: if (tx_valid && !m_s2) begin
                  m_byte <= tx_data; m_mode <= 1; m_t <= 0;
               end
            1: if (m_s2 && m_t < 21 * HP) begin
                  m_mode <= 2; m_hold <= 0;
               end else if (m_t == 24 * HP - 1) begin
                  m_mode <= 0; m_done <= 1'b1;
               end else begin
                  m_t <= m_t + 1;
               end
            default: if (m_s2) m_hold <= 0;
               else if (m_hold == HP - 1) begin m_mode <= 1; m_t <= 0; end
               else m_hold <= m_hold + 1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("ps2_clk", ps2_clk, exp_clk(m_mode, m_t));
         check("ps2_data", ps2_data, exp_data(m_mode, m_t, m_byte));
         check("tx_done", tx_done, m_done);
         check("tx_ready", tx_ready, (m_mode == 0) && !m_s2);
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (tx_valid && tx_ready) acc_q.push_back(cyc + 1);
         if (tx_done) begin
            done_q.push_back(cyc);
            done_rdy_q.push_back(tx_ready);
         end
      end
   end

   always @(negedge ps2_clk) begin
      if (reset === 1'b0) begin
         falls++;
         samp.push_back(ps2_data);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      samp.delete(); acc_q.delete(); done_q.delete(); done_rdy_q.delete();
      falls = 0;
   endtask

   task automatic wait_dones(input string name, input int n, input int budget);
      int k = 0;
      while (done_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check(name, done_q.size(), n);
   endtask

   task automatic check_frame(input string name, input int base, input logic [10:0] exp);
      logic [10:0] act;
      for (int i = 0; i < 11; i++)
         act[i] = (base + i < samp.size()) ? samp[base + i] : 1'bx;
      check(name, act, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      reset = 1'b1; tx_valid = 1'b0; tx_data = '0; host_inhibit = 1'b0;
      tick(3);
      check("reset_clk", ps2_clk, 1'b1);
      check("reset_data", ps2_data, 1'b1);
      check("reset_done", tx_done, 1'b0);
      reset = 1'b0;
      tick(1);
      check("ready_after_reset", tx_ready, 1'b1);

      // A: single byte 0x1C
      clear_mon();
      tx_data = 8'h1C; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0; tx_data = 8'hE7;
      wait_dones("a_done", 1, 200);
      check_frame("a_frame_1c", 0, 11'b100_0011_1000);
      check("a_falls", falls, 11);
      check("a_latency", done_q[0] - acc_q[0], 96);
      check("a_accepts", acc_q.size(), 1);

      // B: 0x00 then 0xFF, tx_valid held
      tick(2);
      clear_mon();
      tx_data = 8'h00; tx_valid = 1'b1;
      tick(1);
      tx_data = 8'hFF;
      r = 0;
      while (acc_q.size() < 2 && r < 200) begin tick(1); r++; end
      tx_valid = 1'b0;
      wait_dones("b_done", 2, 200);
      check_frame("b_frame_00", 0, 11'b110_0000_0000);
      check_frame("b_frame_ff", 11, 11'b111_1111_1110);
      check("b_falls", falls, 22);
      check("b_second_accept", acc_q[1], done_q[0] + 1);
      check("b_ready_at_done", done_rdy_q[0], 1'b1);

      // C: inhibit during data bit 3 of 0xA5, then retransmit
      tick(2);
      clear_mon();
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      tick(37);
      check("c_in_bit3_low", ps2_clk, 1'b0);
      host_inhibit = 1'b1;
      tick(3);
      check("c_abort_clk", ps2_clk, 1'b1);
      check("c_abort_data", ps2_data, 1'b1);
      tick(20);
      check("c_no_done_abort", done_q.size(), 0);
      clear_mon();
      host_inhibit = 1'b0;
      wait_dones("c_done", 1, 300);
      check_frame("c_frame_a5", 0, 11'b111_0100_1010);
      check("c_falls", falls, 11);
      tick(20);
      check("c_single_done", done_q.size(), 1);

      // D: reset pulse during LOW of data bit 5 of 0x3C
      clear_mon();
      tx_data = 8'h3C; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      tick(53);
      check("d_in_bit5_low", ps2_clk, 1'b0);
      reset = 1'b1;
      #1;
      check("d_async_clk", ps2_clk, 1'b1);
      check("d_async_data", ps2_data, 1'b1);
      check("d_async_done", tx_done, 1'b0);
      tick(2);
      reset = 1'b0;
      tick(1);
      check("d_ready_after", tx_ready, 1'b1);
      clear_mon();
      tick(150);
      check("d_no_edges", falls, 0);
      check("d_no_done", done_q.size(), 0);

      // E: inhibit held in IDLE with tx_valid, then release
      clear_mon();
      host_inhibit = 1'b1;
      tick(4);
      tx_data = 8'h5A; tx_valid = 1'b1;
      tick(20);
      check("e_ready_low", tx_ready, 1'b0);
      check("e_no_edges", falls, 0);
      check("e_no_accept", acc_q.size(), 0);
      host_inhibit = 1'b0;
      r = cyc;
      while (acc_q.size() < 1 && cyc - r < 10) tick(1);
      tx_valid = 1'b0;
      check("e_accept_within_3", (acc_q.size() == 1) && (acc_q[0] - r <= 3), 1'b1);
      wait_dones("e_done", 1, 200);
      check_frame("e_frame_5a", 0, 11'b110_1011_0100);

      // F: inhibit arriving after the stop bit's falling edge does not abort
      tick(2);
      clear_mon();
      tx_data = 8'h81; tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      tick(85);
      host_inhibit = 1'b1;
      wait_dones("f_done", 1, 100);
      check_frame("f_frame_81", 0, 11'b111_0000_0010);
      check("f_latency", done_q[0] - acc_q[0], 96);
      tick(2);
      check("f_ready_inhibited", tx_ready, 1'b0);
      host_inhibit = 1'b0;
      tick(4);
      check("f_ready_released", tx_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 Parameter HALF_PERIOD, default 2500, system-clock cycles per PS/2 clock half-period (50 MHz -> 10 kHz).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tx_data  input  8  byte to send (scan code).
REQ-005 tx_valid  input  1  request to send tx_data.
REQ-006 tx_ready  output  1  block can accept a byte this cycle.
REQ-007 host_inhibit  input  1  host holds the PS/2 clock low; asynchronous.
REQ-008 ps2_clk  output  1  device-generated PS/2 clock; idle high.
REQ-009 ps2_data  output  1  PS/2 serial data; idle high.
REQ-010 tx_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 The block SHALL synchronize host_inhibit through a 2-flop synchronizer; "inhibit" below means the synchronized value.
REQ-012 Frame SHALL be 11 bits: start 0, data[0]..data[7] LSB first, odd parity (total ones over data and parity is odd), stop 1.
REQ-013 States SHALL be IDLE, SETUP, LOW, HIGH, GAP, HOLD.
REQ-014 tx_ready SHALL be 1 only in IDLE with inhibit=0.
REQ-015 Handshake: tx_valid and tx_ready both high on an edge -> latch tx_data and parity, set bit index 0, enter SETUP.
REQ-016 tx_data is ignored outside the accepting edge; tx_valid held high while tx_ready=0 SHALL have no effect.
REQ-017 SETUP: ps2_clk=1, ps2_data=start bit 0, for HALF_PERIOD cycles, then LOW.
REQ-018 LOW: ps2_clk=0 for HALF_PERIOD cycles, ps2_data holds the current bit, then HIGH.
REQ-019 HIGH: ps2_clk=1 for HALF_PERIOD cycles. On entry, if bit index <10, increment the index and drive the next bit on ps2_data in the same cycle ps2_clk rises. Leave HIGH to LOW if index <=10 and that bit has not yet been clocked, otherwise to GAP.
REQ-020 Data SHALL never change while ps2_clk=0; each bit is stable across its falling edge.
REQ-021 GAP: ps2_clk=1, ps2_data=1 for HALF_PERIOD cycles, then IDLE with tx_done=1 for exactly that one cycle.
REQ-022 Accept-to-done latency SHALL be exactly 24*HALF_PERIOD cycles (SETUP 1 + 11x(LOW+HIGH) 22 + GAP 1 half-periods).
REQ-023 Exactly 11 falling edges of ps2_clk SHALL occur per completed frame.
REQ-024 Half-period counter SHALL be $clog2(HALF_PERIOD) bits wide, load 0 on every state entry, and terminate at HALF_PERIOD-1.
REQ-025 Inhibit asserted in SETUP, LOW, or HIGH before the stop bit's falling edge SHALL abort the frame:
- next cycle: ps2_clk=1, ps2_data=1, enter HOLD;
- latched byte retained.
REQ-026 Inhibit asserted after the stop bit's falling edge SHALL NOT abort; the frame completes normally.
REQ-027 HOLD: outputs idle-high, tx_ready=0; on inhibit deassert, wait HALF_PERIOD cycles, then retransmit the latched byte from SETUP, bit index 0.
REQ-028 tx_done SHALL NOT pulse for an aborted frame, only for its successful retransmission.
REQ-029 Inhibit in IDLE SHALL hold tx_ready=0 with no state change.

Reset
REQ-030 Reset asserted SHALL immediately force IDLE, ps2_clk=1, ps2_data=1, tx_done=0, counter=0, bit index=0, synchronizer flops=0.
REQ-031 Reset mid-frame SHALL discard the byte; no retransmission after release.
REQ-032 tx_ready SHALL be 1 in the first cycle after reset release when inhibit=0.

Verification (HALF_PERIOD=4)
REQ-033 Send 0x1C -> host model samples on falling edges: 0,0,0,1,1,1,0,0,0,0,1 (parity 0); tx_done exactly 96 cycles after accept.
REQ-034 Send 0x00 then 0xFF back-to-back with tx_valid held -> parity bits 1 and 1; second accept on the cycle tx_done pulses; 22 falling edges total.
REQ-035 Inhibit raised during data bit 3 of 0xA5 -> outputs high within 3 cycles, no tx_done. Release -> full 0xA5 frame resent, then a single tx_done.
REQ-036 Reset pulsed during LOW of bit 5 -> ps2_clk=1, ps2_data=1 asynchronously; tx_ready=1 one cycle after release; no further edges.
REQ-037 Inhibit held in IDLE with tx_valid=1 -> tx_ready=0, no ps2_clk edges. Release -> accept within 3 cycles.
